// File: rtl/psum_collector.sv
// psum_collector: receives zero/partial-sum packets during the CONV stage,
// stores or saturating-accumulates them into a 4 x 64 ofmap buffer indexed by
// (filter_idx, psum_idx), and serves a 1-cycle registered read port.
// Optional feature macro: PSUM_RELU_EN (ReLU applied on the read path only).

`ifndef L1_OFMAP_SIZE
`define L1_OFMAP_SIZE 16
`endif
`ifndef L2_OFMAP_SIZE
`define L2_OFMAP_SIZE 8
`endif
`ifndef L3_OFMAP_SIZE
`define L3_OFMAP_SIZE 13
`endif

package psum_collector_pkg;
    typedef enum logic [1:0] {MODE1, MODE2, MODE3, MODE4} OP_MODE;
    typedef enum logic [1:0] {STG_IDLE, STG_LOAD, CONV, STG_WB} OP_STAGE;
    typedef struct packed {
        logic signed [15:0] psum;
        logic               valid;
        logic [1:0]         filter_idx;
    } PSUM_PACKET;
endpackage

module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int PSUM_W  = 16,
    parameter int L1_SIZE = `L1_OFMAP_SIZE,
    parameter int L2_SIZE = `L2_OFMAP_SIZE,
    parameter int L3_SIZE = `L3_OFMAP_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  PSUM_PACKET               psum_in,
    output logic                     psum_ack,
    input  OP_MODE                   mode_in,
    input  logic                     change_mode,
    input  logic                     conv_continue,
    input  OP_STAGE                  op_stage_in,
    input  logic                     rd_en,
    input  logic [1:0]               rd_filter,
    input  logic [5:0]               rd_idx,
    output logic signed [PSUM_W-1:0] rd_data,
    output logic                     pass_done,
    output logic                     seq_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic signed [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    state_t                     state_reg;
    OP_MODE                     cur_mode_reg;
    logic [1:0]                 exp_filter_reg;
    logic [5:0]                 psum_idx_reg;
    logic                       first_pass_reg;
    logic                       pass_done_reg;
    logic                       seq_err_reg;
    logic signed [PSUM_W-1:0]   rd_data_reg;

    logic [5:0]                 idx_max;
    logic                       last_ack;
    logic signed [PSUM_W-1:0]   pkt_psum;
    logic signed [PSUM_W-1:0]   old_val;
    logic signed [PSUM_W:0]     sum_wide;
    logic signed [PSUM_W-1:0]   wr_data;
    logic signed [PSUM_W-1:0]   rd_raw;
    logic signed [PSUM_W-1:0]   rd_value;
    logic signed [PSUM_W-1:0]   bank_old [4];
    logic signed [PSUM_W-1:0]   bank_rd  [4];

    assign pkt_psum = psum_in.psum;

    // Accept only while collecting in CONV and no pass-boundary command is present.
    assign psum_ack = psum_in.valid && (state_reg == COLLECT) && (op_stage_in == CONV)
                      && !change_mode && !conv_continue;

    assign last_ack = psum_ack && (exp_filter_reg == 2'd3) && (psum_idx_reg == idx_max);

    // Last valid ofmap index for the latched mode.
    always_comb begin
        idx_max = 6'(L3_SIZE - 1);
        case (cur_mode_reg)
            MODE1, MODE2: idx_max = 6'(L1_SIZE - 1);
            MODE3:        idx_max = 6'(L2_SIZE - 1);
            default:      idx_max = 6'(L3_SIZE - 1);
        endcase
    end

    // Saturating accumulate of the addressed entry; first pass overwrites instead.
    always_comb begin
        old_val  = bank_old[psum_in.filter_idx];
        sum_wide = {old_val[PSUM_W-1], old_val} + {pkt_psum[PSUM_W-1], pkt_psum};
        if (first_pass_reg) begin
            wr_data = pkt_psum;
        end else if (sum_wide[PSUM_W] != sum_wide[PSUM_W-1]) begin
            wr_data = sum_wide[PSUM_W] ? SAT_MIN : SAT_MAX;
        end else begin
            wr_data = sum_wide[PSUM_W-1:0];
        end
    end

    // One 64-entry bank per filter; the write goes to the packet's own filter_idx.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic signed [PSUM_W-1:0] mem [64];

            assign bank_old[gi] = mem[psum_idx_reg];
            assign bank_rd[gi]  = mem[rd_idx];

            // Commit the packet on its ack edge; contents are never reset.
            always_ff @(posedge clk) begin
                if (psum_ack && (psum_in.filter_idx == 2'(gi))) begin
                    mem[psum_idx_reg] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_raw = bank_rd[rd_filter];

`ifdef PSUM_RELU_EN
    assign rd_value = rd_raw[PSUM_W-1] ? '0 : rd_raw;
`else
    assign rd_value = rd_raw;
`endif

    // Registered read port; a same-cycle write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_value;
        end
    end

    // Pass control: state, counters, pass flags and sequence error tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_mode_reg   <= MODE1;
            exp_filter_reg <= '0;
            psum_idx_reg   <= '0;
            first_pass_reg <= 1'b1;
            pass_done_reg  <= 1'b0;
            seq_err_reg    <= 1'b0;
        end else begin
            pass_done_reg <= last_ack;
            if (change_mode) begin
                // New layer: abort anything in flight and overwrite on the next pass.
                cur_mode_reg   <= mode_in;
                exp_filter_reg <= '0;
                psum_idx_reg   <= '0;
                first_pass_reg <= 1'b1;
                seq_err_reg    <= 1'b0;
                state_reg      <= IDLE;
            end else if (conv_continue) begin
                exp_filter_reg <= '0;
                psum_idx_reg   <= '0;
                first_pass_reg <= 1'b0;
                if (state_reg == DONE) begin
                    state_reg <= COLLECT;
                end
            end else begin
                if (psum_ack) begin
                    exp_filter_reg <= exp_filter_reg + 2'd1;
                    if (exp_filter_reg == 2'd3) begin
                        psum_idx_reg <= psum_idx_reg + 6'd1;
                    end
                    if (psum_in.filter_idx != exp_filter_reg) begin
                        seq_err_reg <= 1'b1;
                    end
                end
                case (state_reg)
                    IDLE:    if (op_stage_in == CONV) state_reg <= COLLECT;
                    COLLECT: if (last_ack) state_reg <= DONE;
                    default: ;
                endcase
            end
        end
    end

    assign rd_data   = rd_data_reg;
    assign pass_done = pass_done_reg;
    assign seq_err   = seq_err_reg;

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: table-driven and hand-sequenced checks of psum_collector,
// with a read scoreboard (expected read values queued at request time).

module tb_psum_collector;
    import psum_collector_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    PSUM_PACKET         psum_in;
    logic               psum_ack;
    OP_MODE             mode_in;
    logic               change_mode;
    logic               conv_continue;
    OP_STAGE            op_stage_in;
    logic               rd_en;
    logic [1:0]         rd_filter;
    logic [5:0]         rd_idx;
    logic signed [15:0] rd_data;
    logic               pass_done;
    logic               seq_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_q[$];

    typedef struct {
        logic [1:0] f;
        logic [5:0] idx;
        int         exp;
    } rd_vec_t;

    rd_vec_t tbl[6];

    always #5 clk = ~clk;

    psum_collector #(
        .PSUM_W (16),
        .L1_SIZE(16),
        .L2_SIZE(8),
        .L3_SIZE(13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .psum_in      (psum_in),
        .psum_ack     (psum_ack),
        .mode_in      (mode_in),
        .change_mode  (change_mode),
        .conv_continue(conv_continue),
        .op_stage_in  (op_stage_in),
        .rd_en        (rd_en),
        .rd_filter    (rd_filter),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .pass_done    (pass_done),
        .seq_err      (seq_err)
    );

    function automatic int relu(input int v);
`ifdef PSUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One packet; the combinational ack is sampled before the edge that consumes it.
    task automatic send(input int f, input int v, input int exp_ack, input string nm);
        psum_in.valid      = 1'b1;
        psum_in.filter_idx = 2'(f);
        psum_in.psum       = 16'(v);
        #1;
        check(nm, int'(psum_ack), exp_ack);
        tick();
        psum_in.valid = 1'b0;
    endtask

    task automatic do_read(input int f, input int i, input int exp, input string nm);
        rd_en     = 1'b1;
        rd_filter = 2'(f);
        rd_idx    = 6'(i);
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
        check(nm, int'(rd_data), exp_q.pop_front());
    endtask

    // Full 52-ack MODE4 pass; optionally probes [0][0] in the first two ack cycles
    // to see the pre-write value and then the freshly written one.
    task automatic run_pass(input int use_fidx, input int val, input int probe,
                            input int pre, input int post);
        for (int k = 0; k < 52; k++) begin
            int f;
            int v;
            f = k % 4;
            v = (use_fidx != 0) ? (f + 1) : val;
            if (probe != 0 && k < 2) begin
                rd_en     = 1'b1;
                rd_filter = 2'd0;
                rd_idx    = 6'd0;
                exp_q.push_back((k == 0) ? pre : post);
            end else begin
                rd_en = 1'b0;
            end
            if (k == 51) check("pass_done_before_last", int'(pass_done), 0);
            send(f, v, 1, $sformatf("ack_k%0d", k));
            if (probe != 0 && k < 2) check($sformatf("rd_probe_k%0d", k), int'(rd_data), exp_q.pop_front());
        end
        rd_en = 1'b0;
        check("pass_done_pulse", int'(pass_done), 1);
        psum_in.valid      = 1'b1;
        psum_in.filter_idx = 2'd0;
        #1;
        check("ack_after_pass", int'(psum_ack), 0);
        tick();
        psum_in.valid = 1'b0;
        check("pass_done_single", int'(pass_done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{f: 2'd2, idx: 6'd12, exp: 3};
        tbl[1] = '{f: 2'd0, idx: 6'd0,  exp: 1};
        tbl[2] = '{f: 2'd1, idx: 6'd5,  exp: 2};
        tbl[3] = '{f: 2'd3, idx: 6'd12, exp: 4};
        tbl[4] = '{f: 2'd0, idx: 6'd12, exp: 1};
        tbl[5] = '{f: 2'd3, idx: 6'd0,  exp: 4};

        rst           = 1'b1;
        psum_in       = '0;
        mode_in       = MODE1;
        change_mode   = 1'b0;
        conv_continue = 1'b0;
        op_stage_in   = STG_IDLE;
        rd_en         = 1'b0;
        rd_filter     = '0;
        rd_idx        = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_psum_ack", int'(psum_ack), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_pass_done", int'(pass_done), 0);
        check("rst_seq_err", int'(seq_err), 0);

        // Enter MODE4 and start the first (overwriting) pass.
        mode_in     = MODE4;
        change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        op_stage_in = CONV;
        tick();
        run_pass(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            do_read(tbl[i].f, tbl[i].idx, relu(tbl[i].exp), $sformatf("rd_tbl%0d", i));

        // Second pass accumulates +5, third saturates at the positive limit.
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        run_pass(0, 5, 1, 1, 6);
        do_read(2, 12, 8, "rd_pass2_2_12");
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        run_pass(0, 32'h7FFF, 1, 6, 32767);
        do_read(3, 7, 32767, "rd_sat_3_7");

        // Stage gating: no ack outside CONV, buffer untouched, then resume at [0][0].
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        op_stage_in = STG_LOAD;
        send(0, 100, 0, "ack_not_conv");
        do_read(0, 0, 32767, "rd_unchanged");
        op_stage_in = CONV;
        send(0, -1, 1, "ack_resume");
        do_read(0, 0, 32766, "rd_resume_0_0");

        // Out-of-order filter index raises the sticky sequence error.
        send(1, 0, 1, "ack_f1");
        send(2, 0, 1, "ack_f2");
        send(3, 0, 1, "ack_f3");
        check("seq_err_before", int'(seq_err), 0);
        send(2, 0, 1, "ack_bad_filter");
        check("seq_err_set", int'(seq_err), 1);
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        check("seq_err_sticky", int'(seq_err), 1);

        // Simultaneous change_mode and conv_continue mid-pass: abort to IDLE, overwrite next.
        send(0, 1, 1, "ack_mid0");
        send(1, 1, 1, "ack_mid1");
        mode_in            = MODE4;
        change_mode        = 1'b1;
        conv_continue      = 1'b1;
        psum_in.valid      = 1'b1;
        psum_in.filter_idx = 2'd2;
        #1;
        check("ack_during_cmd", int'(psum_ack), 0);
        tick();
        change_mode   = 1'b0;
        conv_continue = 1'b0;
        psum_in.valid = 1'b0;
        check("seq_err_cleared", int'(seq_err), 0);
        send(0, 11, 0, "ack_in_idle");
        send(0, 11, 1, "ack_new0");
        send(1, 22, 1, "ack_new1");
        do_read(1, 0, 22, "rd_overwrite_1_0");
        do_read(0, 0, 11, "rd_overwrite_0_0");

        // Negative store then accumulate back positive at [3][4].
        change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        tick();
        for (int k = 0; k < 20; k++)
            send(k % 4, (k == 19) ? -7 : 0, 1, $sformatf("ack_neg_k%0d", k));
        do_read(3, 4, relu(-7), "rd_neg_3_4");
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        for (int k = 0; k < 20; k++)
            send(k % 4, (k == 19) ? 10 : 0, 1, $sformatf("ack_pos_k%0d", k));
        do_read(3, 4, relu(3), "rd_acc_3_4");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
# psum_collector

Receiving end of the zero/partial-sum packet stream. It consumes `PSUM_PACKET`s during the `CONV` stage and acknowledges each one with `psum_ack`. Each packet is stored or accumulated into an on-chip ofmap buffer indexed by (filter_idx, psum_idx). The stored results are exposed through a 1-cycle read port for the writeback path. The block sits at the bottom of the PE array, opposite the psum source, and mirrors its filter-major, 4-filters-per-index ordering.

## Interface
- `PSUM_W`, 16: signed psum width; must match `PSUM_PACKET.psum`.
- `L1_SIZE`, `` `L1_OFMAP_SIZE ``: ofmap entries per filter in MODE1/MODE2.
- `L2_SIZE`, `` `L2_OFMAP_SIZE ``: entries in MODE3.
- `L3_SIZE`, `` `L3_OFMAP_SIZE ``: entries in MODE4. All sizes are ≤64.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `psum_in` in `PSUM_PACKET`: incoming packet (`psum`, `valid`, `filter_idx[1:0]`).
- `psum_ack` out 1: packet accepted this cycle.
- `mode_in` in `OP_MODE`: mode latched on `change_mode`.
- `change_mode` in 1: new layer; clears counters; the next pass overwrites the buffer.
- `conv_continue` in 1: new input-channel pass; clears counters; the next pass accumulates.
- `op_stage_in` in `OP_STAGE`: collection happens only when the stage is `CONV`.
- `rd_en` in 1: buffer read request.
- `rd_filter` in 2: read filter index.
- `rd_idx` in 6: read ofmap index.
- `rd_data` out `PSUM_W`: read result, 1 cycle after `rd_en`.
- `pass_done` out 1: single-cycle pulse on the final accepted packet of a pass.
- `seq_err` out 1: sticky flag; packet `filter_idx` did not match the expected value.

## Operation
- Storage: 4 × 64 × `PSUM_W` flops. Only entries 0..size-1 of the current mode are written.
- `cur_mode` resets to MODE1 and loads `mode_in` on `change_mode`. `idx_max` = size−1 of `cur_mode`.
- States:
  - `IDLE`: goes to `COLLECT` when `op_stage_in==CONV`.
  - `COLLECT`: goes to `DONE` on the ack of the packet with `exp_filter==3` and `psum_idx==idx_max`.
  - `DONE`: goes to `COLLECT` on `conv_continue`. Goes to `IDLE` on `change_mode`; this takes priority over `conv_continue` when both are high.
- `psum_ack` = `psum_in.valid` & `state==COLLECT` & `op_stage_in==CONV` & ~`change_mode` & ~`conv_continue`.
- Counters:
  - `exp_filter` (2 bit) increments on every ack and wraps 3→0.
  - `psum_idx` (6 bit) increments when `exp_filter` wraps.
  - Both counters clear on rst, `change_mode` and `conv_continue`.
- Write on ack: target is [`psum_in.filter_idx`][`psum_idx`].
  - If `first_pass` is set: store `psum_in.psum`.
  - Otherwise: store the saturating signed sum of the old entry and `psum_in.psum`, clamped to [−2^(PSUM_W−1), 2^(PSUM_W−1)−1].
- `first_pass`: set by rst and `change_mode`; cleared by `conv_continue`.
- If `psum_in.filter_idx != exp_filter` on an ack, `seq_err` is set. The write still uses the packet's `filter_idx`. `seq_err` is cleared only by rst or `change_mode`.
- Packets arriving while `op_stage_in != CONV`, or in `IDLE`/`DONE`, are not acked and not written.

## Timing
- Reset values:
  - `psum_ack`=0, `rd_data`=0, `pass_done`=0, `seq_err`=0.
  - state=`IDLE`, counters=0, `first_pass`=1.
  - Buffer contents are not reset.
- `psum_ack` is combinational within the same cycle as `valid`. The source advances on the following edge.
- The buffer write commits on the ack edge. A read issued in the same cycle to the same entry returns the pre-write value. A read issued in the next cycle returns the new value.
- `pass_done` is registered and goes high the cycle after the final ack, for exactly 1 cycle.
- Maximum throughput is 1 packet per cycle. A pass takes 4·size acks.
- rst mid-pass: the block returns to `IDLE` on the next edge and the partial buffer contents are retained as garbage. `change_mode` mid-pass aborts the pass in the same way, keeps no accumulation state, and sets `first_pass`.

## Configuration
- `PSUM_RELU_EN` defined: `rd_data` clamps negative stored values to 0 (ReLU applied on read). The buffer itself keeps the signed values, so later passes still accumulate correctly.
- Not defined: `rd_data` returns the raw signed stored value.

## Test plan
- MODE4 with `L3_SIZE`=13, `first_pass`, `valid` held high, `psum`=filter_idx+1 → 52 consecutive acks. `pass_done` pulses the cycle after ack 52. Reading [2][12] returns 3. A 53rd `valid` is not acked.
- `conv_continue`, then a second pass with `psum`=5 → reading [0][0] returns 1+5=6. A third pass with `psum`=0x7FFF saturates to 0x7FFF.
- `op_stage_in` ≠ `CONV` with `valid`=1 → `psum_ack`=0 and the buffer is unchanged. Switching to `CONV` resumes acking from filter 0, idx 0.
- Packet with `filter_idx`=2 when `exp_filter`=0 → `seq_err`=1 and stays 1 through `conv_continue`. `change_mode` clears it.
- `change_mode` and `conv_continue` asserted in the same cycle mid-pass → state=`IDLE`, `first_pass`=1, no ack that cycle, and the next pass overwrites (reading [1][0] returns the new value, not a sum).
- With `PSUM_RELU_EN`: store −7 at [3][4] → `rd_data`=0. Add +10 on the next pass → `rd_data`=3.
